// File: rtl/sdpb_pkg.sv
// Shared constants for the camera-to-LCD frame buffer (640x294 pixels, 4-bit luma).
package sdpb_pkg;
  localparam int FRAME_W         = 640;
  localparam int FRAME_H         = 294;
  localparam int SDPB_DEPTH      = FRAME_W * FRAME_H;
  localparam int SDPB_ADDR_WIDTH = 18;
  localparam int SDPB_DATA_WIDTH = 4;

  localparam int RD_BYPASS   = 0;
  localparam int RD_PIPELINE = 1;
endpackage

// File: rtl/sdpb_mem_array.sv
// Block-RAM storage: synchronous write port and registered (stage-1) read port.
module sdpb_mem_array
  import sdpb_pkg::*;
#(
  parameter int DATA_WIDTH = SDPB_DATA_WIDTH,
  parameter int ADDR_WIDTH = SDPB_ADDR_WIDTH,
  parameter int DEPTH      = SDPB_DEPTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] wa_i,
  input  logic [DATA_WIDTH-1:0] wd_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] ra_i,
  input  logic                  rz_i,
  output logic [DATA_WIDTH-1:0] rd_o
);

  // Zero-filled at configuration; resets never touch the array.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};
  logic [DATA_WIDTH-1:0] rd_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[wa_i] <= wd_i;
  end

  // Out-of-range reads fold into the register's sync clear so the BRAM SSR path absorbs it.
  always_ff @(posedge clk_i) begin
    if (rst_i || (re_i && rz_i)) rd_q <= '0;
    else if (re_i)               rd_q <= mem_q[ra_i];
  end

  assign rd_o = rd_q;

endmodule

// File: rtl/gowin_sdpb2.sv
// SDPB-compatible frame buffer wrapper: range checks, optional output register, dout mux.
module gowin_sdpb2
  import sdpb_pkg::*;
#(
  parameter int DATA_WIDTH = SDPB_DATA_WIDTH,
  parameter int ADDR_WIDTH = SDPB_ADDR_WIDTH,
  parameter int DEPTH      = SDPB_DEPTH,
  parameter int READ_MODE  = RD_BYPASS
) (
  input  logic                  clka,
  input  logic                  reseta,
  input  logic                  clkb,
  input  logic                  resetb,
  input  logic                  cea,
  input  logic [ADDR_WIDTH-1:0] ada,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  ceb,
  input  logic [ADDR_WIDTH-1:0] adb,
  input  logic                  oce,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  // Single-clock block: clkb is the same net as clka.
  logic unused_clkb;
  assign unused_clkb = clkb;

  logic                  wr_en;
  logic                  rd_oob;
  logic [DATA_WIDTH-1:0] rd_q;

  // Addresses are never folded; anything past the frame is dropped or reads as zero.
  assign wr_en  = cea && !reseta && ({1'b0, ada} < DEPTH_W);
  assign rd_oob = ({1'b0, adb} >= DEPTH_W);

  sdpb_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk_i (clka),
    .rst_i (resetb),
    .we_i  (wr_en),
    .wa_i  (ada),
    .wd_i  (din),
    .re_i  (ceb),
    .ra_i  (adb),
    .rz_i  (rd_oob),
    .rd_o  (rd_q)
  );

  if (READ_MODE == RD_PIPELINE) begin : g_pipe
    logic [DATA_WIDTH-1:0] out_q, out_d;

    always_comb begin
      out_d = out_q;
      if (oce) out_d = rd_q;
    end

    always_ff @(posedge clka) begin
      if (resetb) out_q <= '0;
      else        out_q <= out_d;
    end

    assign dout = out_q;
  end else begin : g_byp
    logic unused_oce;
    assign unused_oce = oce;
    assign dout       = rd_q;
  end

endmodule

// File: tb/tb_gowin_sdpb2.sv
// Randomized + directed bench; bypass and pipeline instances share stimulus and one reference model.
module tb_gowin_sdpb2;
  localparam int DEPTH = 188160;
  localparam int AW    = 18;
  localparam int DW    = 4;
  localparam int WIN   = 8192;

  logic          clk = 1'b0;
  logic          reseta = 1'b0, resetb = 1'b0, cea = 1'b0, ceb = 1'b0, oce = 1'b0;
  logic [AW-1:0] ada = '0, adb = '0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout0, dout1;

  int n_chk = 0;
  int n_err = 0;

  // Reference: frame store as a plain array plus the two visible read values.
  bit   [DW-1:0] mdl [DEPTH];
  logic [DW-1:0] rd_m = '0, out_m = '0;

  always #5 clk = ~clk;

  gowin_sdpb2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_MODE(0)) u_byp (
    .clka(clk), .reseta(reseta), .clkb(clk), .resetb(resetb), .cea(cea), .ada(ada),
    .din(din), .ceb(ceb), .adb(adb), .oce(oce), .dout(dout0));

  gowin_sdpb2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_MODE(1)) u_pipe (
    .clka(clk), .reseta(reseta), .clkb(clk), .resetb(resetb), .cea(cea), .ada(ada),
    .din(din), .ceb(ceb), .adb(adb), .oce(oce), .dout(dout1));

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge: advance the reference by the read/write rules, then compare both DUTs.
  task automatic cyc();
    logic [DW-1:0] old_rd;
    @(posedge clk);
    old_rd = rd_m;
    if (resetb)   rd_m = '0;
    else if (ceb) rd_m = (int'(adb) < DEPTH) ? mdl[adb] : '0;
    if (resetb)   out_m = '0;
    else if (oce) out_m = old_rd;
    if (cea && !reseta && int'(ada) < DEPTH) mdl[ada] = din;
    #1;
    chk("byp_dout", dout0, rd_m);
    chk("pipe_dout", dout1, out_m);
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    case ($urandom % 4)
      0:       return AW'($urandom % 64);
      1:       return AW'(DEPTH - 4 + int'($urandom % 8));
      2:       return AW'($urandom);
      default: return AW'($urandom % 64);
    endcase
  endfunction

  initial begin
    int base, k;
    logic [AW-1:0] a;
    logic [DW-1:0] e;

    // Reset held three cycles with reads enabled.
    resetb = 1'b1; ceb = 1'b1; oce = 1'b1; adb = 5;
    repeat (3) begin
      cyc();
      chk("rst_byp", dout0, 4'h0);
      chk("rst_pipe", dout1, 4'h0);
    end
    resetb = 1'b0;
    cyc();
    chk("rst_rel", dout0, 4'h0);

    // Basic write/read and unwritten address.
    ceb = 1'b0; cea = 1'b1; ada = 5; din = 4'hA;
    cyc();
    cea = 1'b0; ceb = 1'b1; adb = 5; oce = 1'b1;
    cyc();
    chk("wr_rd", dout0, 4'hA);
    adb = 6;
    cyc();
    chk("unwritten", dout0, 4'h0);
    chk("pipe_lat2", dout1, 4'hA);

    // Pipeline output register gated by oce.
    adb = 5; cyc();
    cyc();
    chk("pipe_a", dout1, 4'hA);
    adb = 6; oce = 1'b0;
    cyc();
    chk("oce_hold", dout1, 4'hA);
    oce = 1'b1;
    cyc();
    chk("oce_resume", dout1, 4'h0);

    // Read-during-write returns old data.
    ceb = 1'b0; cea = 1'b1; ada = 100; din = 4'h3;
    cyc();
    din = 4'h9; ceb = 1'b1; adb = 100;
    cyc();
    chk("rdw_old", dout0, 4'h3);
    cea = 1'b0;
    cyc();
    chk("rdw_new", dout0, 4'h9);

    // Boundaries.
    cea = 1'b1; ada = AW'(DEPTH - 1); din = 4'hF; ceb = 1'b0;
    cyc();
    ada = AW'(DEPTH); din = 4'h7; ceb = 1'b1; adb = AW'(DEPTH - 1);
    cyc();
    chk("last_addr", dout0, 4'hF);
    cea = 1'b0; adb = AW'(DEPTH);
    cyc();
    chk("oob_read", dout0, 4'h0);
    adb = '1;
    cyc();
    chk("max_read", dout0, 4'h0);

    // resetb mid-stream clears both stages, memory intact.
    adb = 5; cyc(); cyc();
    resetb = 1'b1;
    cyc();
    chk("midrst_byp", dout0, 4'h0);
    chk("midrst_pipe", dout1, 4'h0);
    resetb = 1'b0;
    cyc();
    chk("post_rst", dout0, 4'hA);

    // Sweeps over the frame start and end, reading behind the write pointer.
    for (int w = 0; w < 2; w++) begin
      base = (w == 0) ? 0 : DEPTH - WIN;
      k    = base + int'($urandom_range(WIN / 4, 3 * WIN / 4));
      for (int i = 0; i < WIN; i++) begin
        cea = 1'b1; ada = AW'(base + i); din = DW'(base + i);
        reseta = (base + i == k);
        ceb = 1'b1; adb = (i >= 2) ? AW'(base + i - 2) : AW'(base + i);
        oce = 1'($urandom);
        cyc();
      end
      cea = 1'b0; reseta = 1'b0; oce = 1'b1;
      for (int i = 0; i < WIN; i++) begin
        a = AW'(base + i);
        adb = a;
        cyc();
        e = (base + i == k) ? 4'h0 : DW'(base + i);
        chk("sweep", dout0, e);
      end
    end

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cea    = 1'($urandom);
      ceb    = 1'($urandom);
      oce    = 1'($urandom);
      reseta = (($urandom % 16) == 0);
      resetb = (($urandom % 32) == 0);
      ada    = rnd_addr();
      adb    = ($urandom % 4 == 0) ? ada : rnd_addr();
      din    = DW'($urandom);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
